riscv_mc_ctrl: RTL and testbench
================================

# riscv_mc_ctrl

Multi-cycle control unit for the next-generation RISC-V core. It replaces the single-cycle combinational decode with a state machine that sequences FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memories that may insert wait states. It holds the instruction register and traps on illegal opcodes or memory timeouts. It also exports decode trace fields and cycle/retired-instruction counters. It sits between the memories and the datapath; the existing ALU controller consumes its `ALUop_ins`, `Funct3_ins` and `Funct7_ins`.

## Interface
- `DATA_W`, 32: instruction/data word width (instruction fields fixed at RV32I positions).
- `CNT_W`, 64: width of `cycle_cnt` and `instret_cnt`.
- `TIMEOUT`, 255: maximum consecutive memory wait cycles before a bus trap; must be ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold at next instruction boundary.
- `imem_req`  out  1  instruction fetch request.
- `imem_ready`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  DATA_W  fetched instruction.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data access is a store.
- `dmem_ready`  in  1  data access complete this cycle.
- `branch_taken`  in  1  datapath comparator result, valid in EXEC.
- `instr`  out  DATA_W  instruction register.
- `ir_we`  out  1  instruction register and old-PC capture strobe for the datapath.
- `pc_we`  out  1  PC write enable.
- `pc_src`  out  1  0: PC+4, 1: ALU target.
- `alu_src_a`  out  2  00: rs1, 01: old PC, 10: zero.
- `alu_src_b`  out  1  0: rs2, 1: immediate.
- `reg_we`  out  1  register file write.
- `wb_sel`  out  2  00: ALU, 01: memory, 10: old PC+4.
- `opcode_ins`  out  7  `instr[6:0]`.
- `Funct3_ins`  out  3  `instr[14:12]`.
- `Funct7_ins`  out  7  `instr[31:25]`.
- `ALUop_ins`  out  2  00: add, 01: branch compare, 10: R-type, 11: I-ALU.
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- `trap`  out  1  sticky trap flag.
- `trap_cause`  out  2  00: none, 01: illegal opcode, 10: bus timeout.
- `cycle_cnt`  out  CNT_W  cycles since reset.
- `instret_cnt`  out  CNT_W  retired instructions.

## Operation
- Reset (`reset`=0, asynchronous): `state`=FETCH, `instr`=0, `trap`=0, `trap_cause`=00, counters=0, wait counter=0. While `reset`=0, every output is 0.
- The control outputs are decoded combinationally from `state` and `instr`. The only registers are the state, `instr`, trap, the wait counter and the two event counters.
- FETCH:
  - `imem_req` = !`stall`.
  - On `imem_req`&`imem_ready`: `ir_we`=1, `pc_we`=1, `pc_src`=0; `instr` loads `imem_rdata`; go to DECODE.
- DECODE: classify `instr[6:0]`.
  - Legal opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. A legal opcode goes to EXEC.
  - Any other opcode goes to TRAP with cause 01.
- EXEC, per class:
  - R: `alu_src_b`=0.
  - I, LOAD, STORE, JALR: `alu_src_b`=1, `alu_src_a`=00.
  - AUIPC, JAL, BRANCH target: `alu_src_a`=01, `alu_src_b`=1.
  - LUI: `alu_src_a`=10, `alu_src_b`=1.
  - JAL/JALR: `pc_we`=1, `pc_src`=1.
  - BRANCH: `pc_we`=`branch_taken`, `pc_src`=1.
- EXEC next state: LOAD/STORE go to MEM; BRANCH goes to FETCH; all other classes go to WB.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for STORE.
  - On `dmem_ready`: LOAD goes to WB, STORE goes to FETCH.
- WB:
  - `reg_we`=1.
  - `wb_sel`=01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - Always goes to FETCH.
- ALUop by class: LOAD/STORE/AUIPC/JAL/JALR/LUI = 00, BRANCH = 01, R = 10, I = 11.
- Wait counter:
  - Counts cycles in FETCH (with request asserted) or MEM without ready.
  - Clears on ready or on any state change.
  - When it reaches `TIMEOUT` with ready still low, the FSM goes to TRAP with cause 10.
  - Ready arriving in the same cycle that the count reaches `TIMEOUT` completes the access; no trap.
- TRAP:
  - Absorbing state; only reset leaves it.
  - `trap`=1; all request and write enables are 0.
  - Counters freeze.
- `cycle_cnt` increments every cycle outside TRAP.
- `instret_cnt` increments on each transition into FETCH from EXEC, MEM or WB.
- Both counters wrap modulo 2^CNT_W.
- `stall` is sampled only in FETCH. It is ignored once a request has been granted. A stall does not advance the wait counter.

## Timing
- Latency with zero memory waits:
  - BRANCH: 3 cycles.
  - R, I, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- A request stays high until ready is seen.
- First `imem_req` is asserted in the first cycle after reset deasserts, if `stall`=0.
- `instr` and the trap flags update on the rising edge after the qualifying cycle.

## Test plan
- Release reset, one-cycle fetch of 0x00A00093 (ADDI): `state` sequence 0,1,2,4,0; `reg_we` high in WB only; `ALUop_ins`=11; `instret_cnt`=1 after cycle 4.
- LOAD 0x0000A103 with `dmem_ready` delayed 3 cycles: `dmem_req` high for 4 cycles; total latency 8 cycles; `wb_sel`=01 in WB.
- BRANCH with `branch_taken`=1, then with 0: `pc_we` high in EXEC only when taken; 3 cycles each; `ALUop_ins`=01.
- Fetch 0xFFFFFFFF: TRAP after DECODE; `trap`=1, `trap_cause`=01; counters frozen for 10 more cycles.
- `TIMEOUT`=4, `imem_ready` held low: trap with cause 10 after 4 wait cycles. Repeat with ready on the 4th cycle: no trap.
- Assert `reset` low mid-MEM: all outputs 0 immediately. Hold `stall` high: `imem_req` stays 0 and `cycle_cnt` keeps counting.

Source files
------------

// File: rtl/riscv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mc_ctrl
// Purpose  : Multi-cycle RV32I control unit. Sequences FETCH/DECODE/EXEC/
//            MEM/WB, handshakes with instruction and data memories that may
//            insert wait states, holds the instruction register, traps on
//            illegal opcodes or memory timeouts, and keeps cycle and
//            retired-instruction counters.
// Ports    : clk, reset (async, active low), stall
//            imem_req/imem_ready/imem_rdata   instruction fetch handshake
//            dmem_req/dmem_we/dmem_ready      data access handshake
//            branch_taken                     comparator result in EXEC
//            instr, ir_we, pc_we, pc_src,
//            alu_src_a, alu_src_b, reg_we,
//            wb_sel                           datapath control
//            opcode_ins, Funct3_ins,
//            Funct7_ins, ALUop_ins            decode fields for ALU control
//            state, trap, trap_cause,
//            cycle_cnt, instret_cnt           status and counters
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mc_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic              branch_taken,
    output logic [DATA_W-1:0] instr,
    output logic              ir_we,
    output logic              pc_we,
    output logic              pc_src,
    output logic [1:0]        alu_src_a,
    output logic              alu_src_b,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic [6:0]        opcode_ins,
    output logic [2:0]        Funct3_ins,
    output logic [6:0]        Funct7_ins,
    output logic [1:0]        ALUop_ins,
    output logic [2:0]        state,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    // The wait counter only ever holds 0..TIMEOUT-1: the cycle that would
    // take it to TIMEOUT traps instead.
    localparam int                  c_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_BUS     = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_instr;
    logic                r_trap;
    logic [1:0]          r_cause;
    logic [1:0]          w_cause;
    logic [c_WAIT_W-1:0] r_wait;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic [CNT_W-1:0]    r_cycle;
    logic [CNT_W-1:0]    r_instret;

    logic [6:0] w_op;
    logic       w_is_r, w_is_i, w_is_load, w_is_store, w_is_br;
    logic       w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
    logic       w_fetch_req;
    logic       w_wait_last;
    logic       w_retire;

    assign w_op       = r_instr[6:0];
    assign w_is_r     = (w_op == c_OP_R);
    assign w_is_i     = (w_op == c_OP_I);
    assign w_is_load  = (w_op == c_OP_LOAD);
    assign w_is_store = (w_op == c_OP_STORE);
    assign w_is_br    = (w_op == c_OP_BRANCH);
    assign w_is_jal   = (w_op == c_OP_JAL);
    assign w_is_jalr  = (w_op == c_OP_JALR);
    assign w_is_lui   = (w_op == c_OP_LUI);
    assign w_is_auipc = (w_op == c_OP_AUIPC);
    assign w_legal    = w_is_r | w_is_i | w_is_load | w_is_store | w_is_br |
                        w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;

    // A nonzero wait count means a fetch is already outstanding, so stall can
    // no longer withdraw it. The reset gate keeps the request low while the
    // registers are held cleared.
    assign w_fetch_req = reset && (r_state == S_FETCH) && (!stall || (r_wait != '0));
    assign w_wait_last = (r_wait == c_WAIT_LAST);

    always_comb begin
        w_next     = r_state;
        w_cause    = r_cause;
        w_wait_nxt = '0;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 1'b0;
        reg_we     = 1'b0;
        wb_sel     = 2'b00;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = w_fetch_req;
                if (w_fetch_req) begin
                    if (imem_ready) begin
                        ir_we  = 1'b1;
                        pc_we  = 1'b1;
                        w_next = S_DECODE;
                    end else if (w_wait_last) begin
                        w_next  = S_TRAP;
                        w_cause = c_CAUSE_BUS;
                    end else begin
                        w_wait_nxt = r_wait + c_WAIT_W'(1);
                    end
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_next  = S_TRAP;
                    w_cause = c_CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (w_is_r) begin
                    alu_src_b = 1'b0;
                end else if (w_is_lui) begin
                    alu_src_a = 2'b10;
                    alu_src_b = 1'b1;
                end else if (w_is_auipc || w_is_jal || w_is_br) begin
                    alu_src_a = 2'b01;
                    alu_src_b = 1'b1;
                end else begin
                    alu_src_b = 1'b1;
                end
                if (w_is_jal || w_is_jalr) begin
                    pc_we  = 1'b1;
                    pc_src = 1'b1;
                end
                if (w_is_br) begin
                    pc_we  = branch_taken;
                    pc_src = 1'b1;
                end
                if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else if (w_is_br) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ready) begin
                    w_next = w_is_load ? S_WB : S_FETCH;
                end else if (w_wait_last) begin
                    w_next  = S_TRAP;
                    w_cause = c_CAUSE_BUS;
                end else begin
                    w_wait_nxt = r_wait + c_WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                if (w_is_load) begin
                    wb_sel = 2'b01;
                end else if (w_is_jal || w_is_jalr) begin
                    wb_sel = 2'b10;
                end
                w_next = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    always_comb begin
        ALUop_ins = 2'b00;
        if (w_is_br) begin
            ALUop_ins = 2'b01;
        end else if (w_is_r) begin
            ALUop_ins = 2'b10;
        end else if (w_is_i) begin
            ALUop_ins = 2'b11;
        end
    end

    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_instr   <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
            r_wait    <= '0;
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
            r_trap  <= (w_next == S_TRAP);
            r_cause <= w_cause;
            if (ir_we) begin
                r_instr <= imem_rdata;
            end
            if (r_state != S_TRAP) begin
                r_cycle <= r_cycle + CNT_W'(1);
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    assign instr       = r_instr;
    assign opcode_ins  = r_instr[6:0];
    assign Funct3_ins  = r_instr[14:12];
    assign Funct7_ins  = r_instr[31:25];
    assign state       = r_state;
    assign trap        = r_trap;
    assign trap_cause  = r_cause;
    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mc_ctrl
// Purpose  : Self-checking bench for riscv_mc_ctrl. Instruction-level tasks
//            expand each instruction (with its memory wait counts) into a
//            per-cycle list of stimulus plus expected outputs; one runner
//            applies the list and compares every cycle. Literal pins after
//            each segment anchor the expectations to hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mc_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dmem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_src_b, reg_we, trap;
    logic [31:0] instr;
    logic [1:0]  alu_src_a, wb_sel, ALUop_ins, trap_cause;
    logic [6:0]  opcode_ins, Funct7_ins;
    logic [2:0]  Funct3_ins, state;
    logic [63:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    riscv_mc_ctrl #(.DATA_W(32), .CNT_W(64), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken), .instr(instr), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_we(reg_we), .wb_sel(wb_sel), .opcode_ins(opcode_ins),
        .Funct3_ins(Funct3_ins), .Funct7_ins(Funct7_ins), .ALUop_ins(ALUop_ins),
        .state(state), .trap(trap), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef struct {
        logic        rst_n, stall, iready, dready, taken;
        logic [31:0] rdata;
        logic [2:0]  st;
        logic        ireq, irwe, pcwe, pcsrc, bsrc, regwe, dreq, dwe;
        logic [1:0]  asrc, wbsel, aop;
        logic        c_pcsrc, c_alu, c_wb, c_aop;
        logic [31:0] ins;
        logic        trp;
        logic [1:0]  cause;
        logic [63:0] cyc, ret;
    } vec_t;

    vec_t q[$];

    // Architectural model state
    logic [31:0] m_instr;
    logic        m_trap;
    logic [1:0]  m_cause;
    logic [63:0] m_cyc, m_ret;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    // Instruction classes
    localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5,
                   K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9;

    function automatic int cls(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [1:0] aluop_of(input int k);
        if (k == K_BR) return 2'b01;
        if (k == K_R)  return 2'b10;
        if (k == K_I)  return 2'b11;
        return 2'b00;
    endfunction

    function automatic vec_t blank();
        vec_t v;
        v = '{default: '0};
        v.rst_n = 1'b1;
        v.rdata = 32'h1357_9BDF;
        return v;
    endfunction

    task automatic emit(input vec_t v, input bit retire);
        if (!v.rst_n) begin
            m_instr = '0; m_trap = 1'b0; m_cause = 2'b00; m_cyc = '0; m_ret = '0;
        end
        v.ins = m_instr; v.trp = m_trap; v.cause = m_cause; v.cyc = m_cyc; v.ret = m_ret;
        q.push_back(v);
        if (v.rst_n && v.st != 3'd7) m_cyc = m_cyc + 64'd1;
        if (retire) m_ret = m_ret + 64'd1;
    endtask

    task automatic do_reset(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = blank();
            v.rst_n = 1'b0; v.iready = 1'b1; v.dready = 1'b1;
            v.c_pcsrc = 1'b1; v.c_alu = 1'b1; v.c_wb = 1'b1; v.c_aop = 1'b1;
            emit(v, 1'b0);
        end
    endtask

    task automatic do_stall(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = blank();
            v.stall = 1'b1; v.iready = 1'b1;
            emit(v, 1'b0);
        end
    endtask

    task automatic do_trap(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = blank();
            v.st = 3'd7; v.iready = 1'b1; v.dready = 1'b1; v.taken = 1'b1;
            emit(v, 1'b0);
        end
    endtask

    // One instruction: iw fetch waits, dw data waits, tk branch outcome;
    // cut >= 0 stops emitting after that many data wait cycles.
    task automatic do_instr(input logic [31:0] w, input int iw, input int dw,
                            input bit tk, input int cut);
        vec_t v;
        int   k;
        k = cls(w);
        for (int i = 0; i < iw; i++) begin
            v = blank(); v.ireq = 1'b1;
            emit(v, 1'b0);
            if (i + 1 == TO) begin m_trap = 1'b1; m_cause = 2'b10; return; end
        end
        v = blank();
        v.iready = 1'b1; v.rdata = w; v.ireq = 1'b1; v.irwe = 1'b1; v.pcwe = 1'b1;
        v.c_pcsrc = 1'b1;
        emit(v, 1'b0);
        m_instr = w;
        v = blank(); v.st = 3'd1;
        v.c_aop = (k != K_ILL); v.aop = aluop_of(k);
        emit(v, 1'b0);
        if (k == K_ILL) begin m_trap = 1'b1; m_cause = 2'b01; return; end
        v = blank(); v.st = 3'd2; v.taken = tk;
        v.c_alu = 1'b1; v.c_aop = 1'b1; v.aop = aluop_of(k);
        case (k)
            K_R:                   begin v.asrc = 2'b00; v.bsrc = 1'b0; end
            K_LUI:                 begin v.asrc = 2'b10; v.bsrc = 1'b1; end
            K_AUIPC, K_JAL, K_BR:  begin v.asrc = 2'b01; v.bsrc = 1'b1; end
            default:               begin v.asrc = 2'b00; v.bsrc = 1'b1; end
        endcase
        if (k == K_JAL || k == K_JALR) begin v.pcwe = 1'b1; v.pcsrc = 1'b1; v.c_pcsrc = 1'b1; end
        if (k == K_BR) begin v.pcwe = tk; v.pcsrc = 1'b1; v.c_pcsrc = 1'b1; end
        emit(v, k == K_BR);
        if (k == K_BR) return;
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < dw; i++) begin
                if (cut >= 0 && i == cut) return;
                v = blank(); v.st = 3'd3; v.dreq = 1'b1; v.dwe = (k == K_ST);
                v.c_aop = 1'b1; v.aop = aluop_of(k);
                emit(v, 1'b0);
                if (i + 1 == TO) begin m_trap = 1'b1; m_cause = 2'b10; return; end
            end
            v = blank(); v.st = 3'd3; v.dready = 1'b1; v.dreq = 1'b1; v.dwe = (k == K_ST);
            v.c_aop = 1'b1; v.aop = aluop_of(k);
            emit(v, k == K_ST);
            if (k == K_ST) return;
        end
        v = blank(); v.st = 3'd4; v.regwe = 1'b1; v.c_wb = 1'b1;
        v.c_aop = 1'b1; v.aop = aluop_of(k);
        v.wbsel = (k == K_LD) ? 2'b01 : ((k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00);
        emit(v, 1'b1);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got %0h expected %0h", n_vec, nm, act, exp);
        end
    endtask

    task automatic run_q();
        vec_t v;
        while (q.size() > 0) begin
            v = q.pop_front();
            @(posedge clk);
            #1;
            reset = v.rst_n; stall = v.stall; imem_ready = v.iready;
            imem_rdata = v.rdata; dmem_ready = v.dready; branch_taken = v.taken;
            #1;
            n_vec++;
            chk("state", state, v.st);
            chk("imem_req", imem_req, v.ireq);
            chk("ir_we", ir_we, v.irwe);
            chk("pc_we", pc_we, v.pcwe);
            chk("reg_we", reg_we, v.regwe);
            chk("dmem_req", dmem_req, v.dreq);
            chk("dmem_we", dmem_we, v.dwe);
            chk("instr", instr, v.ins);
            chk("opcode_ins", opcode_ins, v.ins[6:0]);
            chk("Funct3_ins", Funct3_ins, v.ins[14:12]);
            chk("Funct7_ins", Funct7_ins, v.ins[31:25]);
            chk("trap", trap, v.trp);
            chk("trap_cause", trap_cause, v.cause);
            chk("cycle_cnt", cycle_cnt, v.cyc);
            chk("instret_cnt", instret_cnt, v.ret);
            if (v.c_pcsrc) chk("pc_src", pc_src, v.pcsrc);
            if (v.c_alu) begin
                chk("alu_src_a", alu_src_a, v.asrc);
                chk("alu_src_b", alu_src_b, v.bsrc);
            end
            if (v.c_wb)  chk("wb_sel", wb_sel, v.wbsel);
            if (v.c_aop) chk("ALUop_ins", ALUop_ins, v.aop);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        m_instr = '0; m_trap = 1'b0; m_cause = 2'b00; m_cyc = '0; m_ret = '0;

        // Reset
        do_reset(2);
        run_q();
        chk("pin_reset_imem_req", imem_req, 64'd0);
        chk("pin_reset_cycle", cycle_cnt, 64'd0);

        // ADDI, no waits, then one stall cycle
        do_instr(32'h00A0_0093, 0, 0, 1'b0, -1);
        do_stall(1);
        run_q();
        chk("pin_addi_instret", instret_cnt, 64'd1);
        chk("pin_addi_cycle", cycle_cnt, 64'd4);
        chk("pin_addi_aluop", ALUop_ins, 64'd3);
        chk("pin_addi_instr", instr, 64'h00A0_0093);

        // LOAD with three data wait cycles: WB lands at cycle 12
        do_instr(32'h0000_A103, 0, 3, 1'b0, -1);
        run_q();
        chk("pin_load_cycle", cycle_cnt, 64'd12);
        chk("pin_load_wb_sel", wb_sel, 64'd1);
        chk("pin_load_instret", instret_cnt, 64'd1);

        // BEQ taken, then not taken
        do_instr(32'h0020_8463, 0, 0, 1'b1, -1);
        do_instr(32'h0020_8463, 0, 0, 1'b0, -1);
        run_q();
        chk("pin_br_cycle", cycle_cnt, 64'd18);
        chk("pin_br_pc_we", pc_we, 64'd0);
        chk("pin_br_aluop", ALUop_ins, 64'd1);
        chk("pin_br_instret", instret_cnt, 64'd3);

        // Remaining classes, including fetch waits up to the boundary
        do_instr(32'h0080_00EF, 0, 0, 1'b0, -1);
        do_instr(32'h0020_A223, 0, 1, 1'b0, -1);
        do_instr(32'h1234_50B7, 0, 0, 1'b0, -1);
        do_instr(32'h0020_81B3, 0, 0, 1'b0, -1);
        do_instr(32'h0000_0117, 3, 0, 1'b0, -1);
        do_instr(32'h0000_80E7, 1, 0, 1'b0, -1);
        do_stall(3);
        run_q();
        chk("pin_mix_instret", instret_cnt, 64'd10);

        // Illegal opcode
        do_reset(1);
        do_instr(32'hFFFF_FFFF, 0, 0, 1'b0, -1);
        do_trap(10);
        run_q();
        chk("pin_ill_state", state, 64'd7);
        chk("pin_ill_trap", trap, 64'd1);
        chk("pin_ill_cause", trap_cause, 64'd1);
        chk("pin_ill_cycle", cycle_cnt, 64'd2);
        chk("pin_ill_instret", instret_cnt, 64'd0);

        // Fetch timeout
        do_reset(1);
        do_instr(32'h00A0_0093, 6, 0, 1'b0, -1);
        do_trap(3);
        run_q();
        chk("pin_ito_cause", trap_cause, 64'd2);
        chk("pin_ito_cycle", cycle_cnt, 64'd4);

        // Data timeout on a store
        do_reset(1);
        do_instr(32'h0020_A223, 0, 5, 1'b0, -1);
        do_trap(2);
        run_q();
        chk("pin_dto_cause", trap_cause, 64'd2);
        chk("pin_dto_cycle", cycle_cnt, 64'd7);
        chk("pin_dto_dmem_req", dmem_req, 64'd0);

        // Reset in the middle of MEM, then held stall
        do_reset(1);
        do_instr(32'h0000_A103, 0, 9, 1'b0, 2);
        do_reset(1);
        do_stall(5);
        run_q();
        chk("pin_stall_imem_req", imem_req, 64'd0);
        chk("pin_stall_cycle", cycle_cnt, 64'd4);
        chk("pin_stall_state", state, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
